// File: rtl/hex_counter_pkg.sv
// -----------------------------------------------------------------------------
// hex_counter_pkg
// Shared types and constants for the four-digit hex counter.
//   state_t      : run/stop FSM encoding
//   COUNT_W      : width of the binary count (four hex digits)
//   NIBBLE_W     : width of one hex digit
//   NUM_DIGITS   : number of displayed digits
//   calc_div     : clock cycles per count tick
//   presc_width  : bits needed for a prescaler running 0..div-1 (ceil-log2, min 1)
// -----------------------------------------------------------------------------
package hex_counter_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int COUNT_W    = 16;
  localparam int NIBBLE_W   = 4;
  localparam int NUM_DIGITS = 4;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Smallest w >= 1 with 2**w >= div, so the prescaler can hold div-1.
  function automatic int presc_width(input int div);
    int w;
    w = 1;
    while ((1 << w) < div) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_counter_4d_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings an asynchronous active-low push-button into the clk domain and
// turns each press (falling edge) into a single-cycle pulse. No debounce:
// a bouncing contact yields several pulses.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (flops reset to "released")
//   btn_n  : raw active-low button, asynchronous to clk
//   press  : one-clk pulse per falling edge of btn_n
// -----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic dly_p2;

  // Two synchronizer stages followed by one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      dly_p2  <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
    end
  end

  // High only in the cycle where the synchronized level has just dropped.
  assign press = dly_p2 & ~sync_p1;

endmodule

// File: rtl/hex_counter_4d.sv
// -----------------------------------------------------------------------------
// hex_counter_4d
// Four-digit hexadecimal up/down counter with start/stop, clear and parallel
// load, driving four downstream hex-to-7-segment decoders.
//   Parameters:
//     CLK_HZ       : input clock frequency in Hz
//     TICK_HZ      : count rate in Hz (DIV = CLK_HZ/TICK_HZ, must be >= 2)
//   Ports:
//     clk          : system clock
//     rst_n        : asynchronous active-low reset
//     start_stop_n : active-low button, each press toggles run/stop
//     clear_n      : active-low button, clears count and stops
//     up_down      : 1 = count up, 0 = count down (used on tick)
//     load         : load load_value every cycle while stopped
//     load_value   : parallel load value, [3:0] -> digit0
//     digit0..3    : hex nibbles of the count, digit0 least significant
//     running      : high while the FSM is in RUNNING
//     wrap         : one-cycle pulse coincident with a wrapped count value
// -----------------------------------------------------------------------------
module hex_counter_4d
  import hex_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop_n,
  input  logic        clear_n,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        running,
  output logic        wrap
);

  localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRESC_W = presc_width(DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("hex_counter_4d: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic start_press;
  logic clear_press;

  btn_sync_edge u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (start_stop_n),
    .press (start_press)
  );

  btn_sync_edge u_clear_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (clear_n),
    .press (clear_press)
  );

  state_t               state_q, state_d;
  logic                 running_q;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic                 tick;

  always_comb begin
    state_d = state_q;
    presc_d = '0;
    count_d = count_q;
    wrap_d  = 1'b0;

    tick = (state_q == RUNNING) && (presc_q == PRESC_MAX);

    // Clear wins over a simultaneous start press.
    if (clear_press) begin
      state_d = STOPPED;
    end else if (start_press) begin
      state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
    end

    // The prescaler only advances while staying in RUNNING; it is zero on the
    // cycle RUNNING is entered, so the first tick lands DIV cycles later.
    if ((state_q == RUNNING) && (state_d == RUNNING)) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    // A tick coinciding with a stop press still updates the count.
    if (clear_press) begin
      count_d = '0;
    end else if ((state_q == STOPPED) && load) begin
      count_d = load_value;
    end else if (tick) begin
      if (up_down) begin
        count_d = count_q + COUNT_W'(1);
        wrap_d  = (count_q == '1);
      end else begin
        count_d = count_q - COUNT_W'(1);
        wrap_d  = (count_q == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STOPPED;
      running_q <= 1'b0;
      presc_q   <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUNNING);
      presc_q   <= presc_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
    end
  end

  assign digit0  = count_q[NIBBLE_W-1:0];
  assign digit1  = count_q[2*NIBBLE_W-1:NIBBLE_W];
  assign digit2  = count_q[3*NIBBLE_W-1:2*NIBBLE_W];
  assign digit3  = count_q[4*NIBBLE_W-1:3*NIBBLE_W];
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_hex_counter_4d.sv
// -----------------------------------------------------------------------------
// tb_hex_counter_4d
// Scoreboard bench for hex_counter_4d with CLK_HZ=10, TICK_HZ=2 (DIV=5).
// Stimulus pushes the hand-computed sequence of count values (with the wrap
// flag expected alongside each) into a queue; the monitor pops one entry every
// time the displayed count changes and requires wrap low on all other cycles.
// -----------------------------------------------------------------------------
module tb_hex_counter_4d;

  typedef struct packed {
    logic [15:0] cnt;
    logic        wrap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_stop_n;
  logic        clear_n;
  logic        up_down;
  logic        load;
  logic [15:0] load_value;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        running;
  logic        wrap;
  logic [15:0] cnt;

  exp_t sb[$];
  int   n_total;
  int   n_pass;

  hex_counter_4d #(
    .CLK_HZ  (10),
    .TICK_HZ (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_stop_n (start_stop_n),
    .clear_n      (clear_n),
    .up_down      (up_down),
    .load         (load),
    .load_value   (load_value),
    .digit0       (digit0),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .running      (running),
    .wrap         (wrap)
  );

  assign cnt = {digit3, digit2, digit1, digit0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic expect_cnt(input logic [15:0] c, input logic w);
    exp_t e;
    e.cnt  = c;
    e.wrap = w;
    sb.push_back(e);
  endtask

  // Returns 2 ns after the n-th following rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Buttons fall before edge E1; the state change lands on E3. Returns 1 ns
  // after E3 with the buttons released.
  task automatic press(input bit s, input bit c, input bit chk);
    if (s) start_stop_n = 1'b0;
    if (c) clear_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (chk) check("running_before_e3", running, 0);
    @(posedge clk);
    #1;
    if (chk) check("running_at_e3", running, 1);
    start_stop_n = 1'b1;
    clear_n      = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  // Monitor: every count change must match the next scoreboard entry; wrap
  // must be low whenever the count did not just change.
  initial begin
    logic [15:0] last;
    exp_t        e;
    last = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        last = 16'h0000;
      end else if (cnt !== last) begin
        if (sb.size() == 0) begin
          check("count_unexpected_change", cnt, last);
        end else begin
          e = sb.pop_front();
          check("count", cnt, e.cnt);
          check("wrap_with_count", wrap, e.wrap);
        end
        last = cnt;
      end else begin
        check("wrap_idle", wrap, 0);
      end
    end
  end

  initial begin
    n_total      = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    start_stop_n = 1'b1;
    clear_n      = 1'b1;
    up_down      = 1'b1;
    load         = 1'b0;
    load_value   = 16'h0000;

    // Reset and idle
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(20);
    check("rst_digit0", digit0, 0);
    check("rst_digit1", digit1, 0);
    check("rst_digit2", digit2, 0);
    check("rst_digit3", digit3, 0);
    check("rst_running", running, 0);

    // Count up ten ticks, then stop
    up_down = 1'b1;
    for (int i = 1; i <= 10; i++) expect_cnt(16'(i), 1'b0);
    press(1'b1, 1'b0, 1'b1);
    idle(50);
    press(1'b1, 1'b0, 1'b0);
    check("stop_running", running, 0);
    check("up_count_000a", cnt, 16'h000a);

    // Up wrap from FFFE
    expect_cnt(16'hfffe, 1'b0);
    expect_cnt(16'hffff, 1'b0);
    expect_cnt(16'h0000, 1'b1);
    do_load(16'hfffe);
    press(1'b1, 1'b0, 1'b0);
    idle(10);
    press(1'b1, 1'b0, 1'b0);
    check("up_wrap_end", cnt, 16'h0000);

    // Down wrap from 0001
    up_down = 1'b0;
    expect_cnt(16'h0001, 1'b0);
    expect_cnt(16'h0000, 1'b0);
    expect_cnt(16'hffff, 1'b1);
    expect_cnt(16'hfffe, 1'b0);
    do_load(16'h0001);
    press(1'b1, 1'b0, 1'b0);
    idle(15);
    press(1'b1, 1'b0, 1'b0);
    check("down_wrap_end", cnt, 16'hfffe);

    // Clear together with start while running at 0123
    up_down = 1'b1;
    for (int i = 0; i < 4; i++) expect_cnt(16'h0120 + 16'(i), 1'b0);
    expect_cnt(16'h0000, 1'b0);
    do_load(16'h0120);
    press(1'b1, 1'b0, 1'b0);
    idle(13);
    press(1'b1, 1'b1, 1'b0);
    check("clear_running", running, 0);
    check("clear_count", cnt, 16'h0000);
    idle(20);
    check("clear_hold_count", cnt, 16'h0000);
    check("clear_hold_running", running, 0);

    // Load ignored while running, then asynchronous reset before a tick
    expect_cnt(16'h0001, 1'b0);
    expect_cnt(16'h0002, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    #1;
    load       = 1'b1;
    load_value = 16'h5a5a;
    idle(12);
    load = 1'b0;
    idle(2);
    check("run_load_ignored", cnt, 16'h0002);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", cnt, 16'h0000);
    check("async_rst_running", running, 0);
    check("async_rst_wrap", wrap, 0);
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check("post_rst_count", cnt, 16'h0000);
    check("post_rst_running", running, 0);

    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_counter_4d.md
Name: hex_counter_4d

Overview:
- Four-digit hexadecimal up/down counter with start/stop control, clear and parallel load. It is driven by board push-buttons and switches.
- It sits directly upstream of the per-digit hex-to-7-segment decoders. digit0..digit3 each drive one decoder's 4-bit nibble input, giving HEX0..HEX3.
- It contains an internal prescaler that produces the count rate from the 50 MHz board clock.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 10, count rate in Hz. DIV = CLK_HZ/TICK_HZ. DIV must be at least 2; this is checked at elaboration.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_stop_n  in  1  push-button, active-low, asynchronous to clk. Each press toggles run/stop.
- clear_n  in  1  push-button, active-low, asynchronous to clk. A press clears the count and stops the counter.
- up_down  in  1  switch level, sampled on tick: 1 = count up, 0 = count down.
- load  in  1  switch level, synchronous use: load load_value while stopped.
- load_value  in  16  value to load. Nibble [3:0] goes to digit0.
- digit0  out  4  least significant hex nibble, to decoder.
- digit1  out  4  nibble [7:4].
- digit2  out  4  nibble [11:8].
- digit3  out  4  most significant nibble [15:12].
- running  out  1  high while the FSM is in RUNNING.
- wrap  out  1  one-cycle pulse on FFFF->0000 (up) or 0000->FFFF (down).

Behaviour:
- Reset (rst_n low, asynchronous): count = 16'h0000, FSM = STOPPED, prescaler = 0, wrap = 0, running = 0. Button synchronizer flops reset to 1 (released).
- Button conditioning, per button:
  - 2-flop synchronizer, then a delayed flop.
  - press pulse = delayed & ~sync2. It is high for exactly one clk per falling edge.
  - Holding a button produces no further pulses.
  - Latency: input falls before edge E1; pulse is high in the cycle after E2; the resulting state change happens at E3.
  - There is no debounce in this block. Bounce produces multiple pulses and is acceptable.
- FSM, two states, STOPPED and RUNNING:
  - STOPPED --start press--> RUNNING.
  - RUNNING --start press--> STOPPED.
  - Any state --clear press--> STOPPED.
  - running = (state == RUNNING), registered.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING. tick = 1 for the cycle where prescaler == DIV-1, and prescaler wraps to 0.
  - In STOPPED the prescaler is held at 0. The first tick after a start therefore occurs DIV cycles after entering RUNNING.
- Count update, priority high to low:
  1. Clear press: count <= 0, prescaler <= 0, state <= STOPPED, wrap <= 0. This takes precedence over a simultaneous start press and over a simultaneous tick.
  2. load = 1 in STOPPED: count <= load_value on every cycle load is high. load is ignored in RUNNING.
  3. tick in RUNNING: count <= count + 1 if up_down = 1, else count - 1. This is modulo 2^16, a pure binary count, so nibble carries are ordinary hex carries (digit0 F->0 increments digit1).
- wrap:
  - Registered. It is set at the same edge that loads the wrapped value, and cleared on the next edge.
  - Up: count was FFFF on tick, giving 0000 with wrap = 1. Down: count was 0000 on tick, giving FFFF with wrap = 1.
  - Load or clear never asserts wrap.
- Start press and tick in the same cycle while RUNNING: the tick count still applies, then the FSM goes to STOPPED.
- Changing up_down mid-run takes effect at the next tick, with no glitch on the count.
- Digits are registered slices of count and are stable between updates. The decoder is purely combinational downstream.
- Reset asserted mid-run: all state is cleared immediately. After release the counter starts STOPPED at 0000.

Decomposition:
- Package hex_counter_pkg:
  - state enum {STOPPED, RUNNING}.
  - Localparams: COUNT_W = 16, NIBBLE_W = 4, NUM_DIGITS = 4.
  - DIV computation function using ceil-log2 for the prescaler width.
- Sub-module btn_sync_edge: ports clk, rst_n, btn_n, press. It contains the 2-flop synchronizer plus falling-edge detect and is instantiated twice.
- Top-level: FSM, prescaler, count register, wrap register. Expected size is about 150-200 lines of RTL in total.

Test Plan (CLK_HZ = 10, TICK_HZ = 2, so DIV = 5):
- Reset then idle 20 cycles -> digits 0,0,0,0; running = 0; wrap never high.
- Start press, up_down = 1, run 50 cycles -> running high at the 3rd edge after the press; count increments every 5 cycles, giving 000A after 10 ticks.
- load = 1 with load_value = 16'hFFFE while stopped, release load, start, up -> FFFF, then 0000 with wrap high for exactly 1 cycle coincident with 0000.
- Load 16'h0001, start, up_down = 0 -> 0000, then FFFF with a 1-cycle wrap; then FFFE with wrap low.
- While running at count 0x0123, clear press together with start press on the same cycle -> count 0000, STOPPED, running = 0; count stays 0000 for 20 cycles.
- load = 1 with load_value = 16'h5A5A while RUNNING -> ignored, counting continues. Separately, assert rst_n low mid-tick -> outputs go 0 asynchronously without waiting for clk.
